org_eth2audio_deinterleaved_depacketizer: RTL and testbench

- Receive-side counterpart of the audio2eth interleaved packetizer: accepts UDP-payload words of interleaved stereo audio on an AXI4-Stream slave, validates the packet header and length, deinterleaves the L/R words into stereo frames, and buffers them in a commit/rollback FIFO.
- Only complete, well-formed packets ever become visible on the frame output; malformed packets are discarded whole.
- Sits between the Ethernet RX path and the audio DAC/I2S frame consumer.

---
 rtl/org_eth2audio_deinterleaved_depacketizer.sv | 128 ++++++++++++
 tb/tb_org_eth2audio_deinterleaved_depacketizer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/org_eth2audio_deinterleaved_depacketizer.sv
// org_eth2audio_deinterleaved_depacketizer: validates interleaved stereo UDP payloads and commits whole packets into a frame FIFO
module org_eth2audio_deinterleaved_depacketizer #(
    parameter int         SAMPLE_WIDTH    = 24,
    parameter int         FIFO_ADDR_WIDTH = 8,
    parameter logic [7:0] MAGIC           = 8'hA5
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [31:0]                s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [SAMPLE_WIDTH-1:0]    m_frame_left,
    output logic [SAMPLE_WIDTH-1:0]    m_frame_right,
    output logic                       m_frame_valid,
    input  logic                       m_frame_ready,
    output logic [15:0]                pkt_ok_count,
    output logic [15:0]                pkt_drop_count,
    output logic [15:0]                seq_gap_count,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);
    localparam int SW = SAMPLE_WIDTH;
    localparam int AW = FIFO_ADDR_WIDTH;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {HDR, PAY_L, PAY_R, DISCARD} state_t;

    state_t          r_state, w_next;
    logic            r_tready;
    logic [7:0]      r_n, r_cnt;
    logic [15:0]     r_seq, r_exp_seq;
    logic            r_seq_seen;
    logic [SW-1:0]   r_left;
    logic [AW:0]     r_spec_ptr, r_commit_ptr, r_rd_ptr;
    logic [15:0]     r_ok, r_drop, r_gap;
    logic [2*SW-1:0] r_mem [0:(1<<AW)-1];

    logic            w_beat, w_hdr_bad, w_last_frame, w_wr, w_commit, w_rollback, w_drop, w_pop;
    logic [AW:0]     w_level, w_space;
    logic [2*SW-1:0] w_head;

    assign w_beat       = s_axis_tvalid && r_tready;
    assign w_level      = r_commit_ptr - r_rd_ptr;
    assign w_space      = DEPTH - w_level;
    assign w_last_frame = r_cnt == r_n - 8'd1;
    assign w_hdr_bad    = s_axis_tdata[31:24] != MAGIC || s_axis_tdata[23:16] == 8'd0 || s_axis_tlast
                          || 32'(s_axis_tdata[23:16]) > 32'(w_space);
    assign w_pop        = m_frame_valid && m_frame_ready;
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];

    assign s_axis_tready  = r_tready;
    assign m_frame_valid  = r_rd_ptr != r_commit_ptr;
    assign m_frame_left   = m_frame_valid ? w_head[2*SW-1:SW] : '0;
    assign m_frame_right  = m_frame_valid ? w_head[SW-1:0] : '0;
    assign pkt_ok_count   = r_ok;
    assign pkt_drop_count = r_drop;
    assign seq_gap_count  = r_gap;
    assign fifo_level     = w_level;

    // State register; reset abandons any partial packet
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= HDR;
        else        r_state <= w_next;
    end

    // Next state: a long packet rolls back and keeps swallowing until its tlast
    always_comb begin
        w_next = r_state;
        if (w_beat)
            case (r_state)
                HDR:     w_next = w_hdr_bad ? (s_axis_tlast ? HDR : DISCARD) : PAY_L;
                PAY_L:   w_next = s_axis_tlast ? HDR : PAY_R;
                PAY_R:   w_next = s_axis_tlast ? HDR : (w_last_frame ? DISCARD : PAY_L);
                DISCARD: w_next = s_axis_tlast ? HDR : DISCARD;
            endcase
    end

    // Control strobes: speculative write, commit, rollback and drop accounting
    always_comb begin
        w_wr       = w_beat && r_state == PAY_R;
        w_commit   = w_wr && w_last_frame && s_axis_tlast;
        w_rollback = w_beat && ((r_state == PAY_L && s_axis_tlast) || (r_state == PAY_R && w_last_frame != s_axis_tlast));
        w_drop     = w_beat && s_axis_tlast && (r_state == HDR ? w_hdr_bad : r_state == PAY_R ? !w_last_frame : 1'b1);
    end

    // Datapath: header latch, pointers, sequence tracking and saturating counters
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_tready     <= 1'b0;
            r_n          <= '0;
            r_cnt        <= '0;
            r_seq        <= '0;
            r_exp_seq    <= '0;
            r_seq_seen   <= 1'b0;
            r_left       <= '0;
            r_spec_ptr   <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_ok         <= '0;
            r_drop       <= '0;
            r_gap        <= '0;
        end else begin
            r_tready <= 1'b1;
            if (w_beat && r_state == HDR) begin
                r_n   <= s_axis_tdata[23:16];
                r_seq <= s_axis_tdata[15:0];
                r_cnt <= '0;
            end
            if (w_beat && r_state == PAY_L) r_left <= s_axis_tdata[SW-1:0];
            if (w_wr) r_cnt <= r_cnt + 8'd1;
            r_spec_ptr <= w_rollback ? r_commit_ptr : w_wr ? r_spec_ptr + 1'b1 : r_spec_ptr;
            if (w_commit) begin
                r_commit_ptr <= r_spec_ptr + 1'b1;
                r_ok         <= r_ok + 16'(r_ok != 16'hFFFF);
                r_exp_seq    <= r_seq + 16'd1;
                r_seq_seen   <= 1'b1;
                if (r_seq_seen && r_seq != r_exp_seq) r_gap <= r_gap + 16'(r_gap != 16'hFFFF);
            end
            if (w_drop) r_drop <= r_drop + 16'(r_drop != 16'hFFFF);
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Frame storage; only the speculative region past commit_ptr is ever written
    always_ff @(posedge ACLK) begin
        if (w_wr) r_mem[r_spec_ptr[AW-1:0]] <= {r_left, s_axis_tdata[SW-1:0]};
    end
endmodule

// File: tb/tb_org_eth2audio_deinterleaved_depacketizer.sv
// tb_org_eth2audio_deinterleaved_depacketizer: scoreboard bench for the deinterleaving depacketizer
module tb_org_eth2audio_deinterleaved_depacketizer;
    logic        ACLK = 0;
    logic        ARESET = 1;
    logic [31:0] s_axis_tdata = 0;
    logic        s_axis_tvalid = 0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 0;
    logic [23:0] m_frame_left, m_frame_right;
    logic        m_frame_valid;
    logic        m_frame_ready = 0;
    logic [15:0] pkt_ok_count, pkt_drop_count, seq_gap_count;
    logic [8:0]  fifo_level;

    int total = 0;
    int bad = 0;
    logic [47:0] expq[$];

    org_eth2audio_deinterleaved_depacketizer dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_frame_left(m_frame_left), .m_frame_right(m_frame_right),
        .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
        .pkt_ok_count(pkt_ok_count), .pkt_drop_count(pkt_drop_count),
        .seq_gap_count(seq_gap_count), .fifo_level(fifo_level)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        chk("tready", {31'd0, s_axis_tready}, 1);
        s_axis_tdata  = w;
        s_axis_tvalid = 1;
        s_axis_tlast  = last;
        @(posedge ACLK);
        #1;
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
    endtask

    task automatic send_pkt(input logic [7:0] magic, input logic [7:0] n, input logic [15:0] seq,
                            input int nw, input int base, input bit good);
        if (good)
            for (int k = 0; k < int'(n); k++)
                expq.push_back({24'(base + 2 * k), 24'(base + 2 * k + 1)});
        send_word({magic, n, seq}, nw == 0);
        for (int i = 0; i < nw; i++)
            send_word({8'hEE, 24'(base + i)}, i == nw - 1);
    endtask

    task automatic drain();
        int cyc = 0;
        m_frame_ready = 1;
        while ((expq.size() != 0 || m_frame_valid) && cyc < 1000) begin
            @(posedge ACLK);
            #1;
            cyc++;
        end
        if (cyc >= 1000) chk("drain_timeout", 1, 0);
        chk("level_drained", 32'(fifo_level), 0);
        m_frame_ready = 0;
    endtask

    task automatic chk_counts(input string tag, input int ok, input int drop, input int gap, input int lvl);
        chk({tag, "_ok"}, 32'(pkt_ok_count), ok);
        chk({tag, "_drop"}, 32'(pkt_drop_count), drop);
        chk({tag, "_gap"}, 32'(seq_gap_count), gap);
        chk({tag, "_level"}, 32'(fifo_level), lvl);
    endtask

    initial begin
        fork
            forever begin
                @(negedge ACLK);
                if (m_frame_valid && m_frame_ready) begin
                    if (expq.size() == 0) chk("unexpected_frame", {8'd0, m_frame_left}, 32'hFFFF_FFFF);
                    else begin
                        logic [47:0] e;
                        e = expq.pop_front();
                        chk("frame_left", {8'd0, m_frame_left}, {8'd0, e[47:24]});
                        chk("frame_right", {8'd0, m_frame_right}, {8'd0, e[23:0]});
                    end
                end
            end
        join_none

        #2;
        chk("rst_tready", {31'd0, s_axis_tready}, 0);
        chk("rst_valid", {31'd0, m_frame_valid}, 0);
        chk_counts("rst", 0, 0, 0, 0);
        @(posedge ACLK);
        #1 ARESET = 0;
        @(posedge ACLK);
        #1;
        chk("tready_after_rst", {31'd0, s_axis_tready}, 1);

        expq.push_back({24'd1, 24'd2});
        expq.push_back({24'd3, 24'd4});
        send_word(32'hA502_0010, 0);
        send_word(32'hEE00_0001, 0);
        send_word(32'hEE00_0002, 0);
        send_word(32'hEE00_0003, 0);
        chk("valid_before_commit", {31'd0, m_frame_valid}, 0);
        send_word(32'hEE00_0004, 1);
        chk("valid_after_commit", {31'd0, m_frame_valid}, 1);
        chk("head_left", {8'd0, m_frame_left}, 1);
        chk_counts("t1", 1, 0, 0, 2);
        drain();

        send_pkt(8'h5A, 8'd2, 16'h0011, 4, 'h100, 0);
        chk_counts("bad_magic", 1, 1, 0, 0);
        send_pkt(8'hA5, 8'd3, 16'h0012, 4, 'h200, 0);
        chk_counts("short", 1, 2, 0, 0);
        send_pkt(8'hA5, 8'd3, 16'h0013, 8, 'h300, 0);
        chk_counts("long", 1, 3, 0, 0);
        chk("long_valid", {31'd0, m_frame_valid}, 0);

        m_frame_ready = 1;
        send_pkt(8'hA5, 8'd1, 16'hFFFE, 2, 'h400, 1);
        chk("seq_fffe_gap", 32'(seq_gap_count), 1);
        send_pkt(8'hA5, 8'd1, 16'hFFFF, 2, 'h410, 1);
        send_pkt(8'hA5, 8'd1, 16'h0000, 2, 'h420, 1);
        chk("seq_wrap_gap", 32'(seq_gap_count), 1);
        send_pkt(8'hA5, 8'd1, 16'h0005, 2, 'h430, 1);
        drain();
        chk_counts("seq", 5, 3, 2, 0);

        send_pkt(8'hA5, 8'd255, 16'h0006, 510, 'h1000, 1);
        chk_counts("fill255", 6, 3, 2, 255);
        send_pkt(8'hA5, 8'd2, 16'h0100, 4, 'h2000, 0);
        chk_counts("nospace", 6, 4, 2, 255);
        send_pkt(8'hA5, 8'd1, 16'h0007, 2, 'h3000, 1);
        chk_counts("full", 7, 4, 2, 256);
        m_frame_ready = 1;
        @(posedge ACLK);
        @(posedge ACLK);
        #1 m_frame_ready = 0;
        chk("pop2_level", 32'(fifo_level), 254);
        send_pkt(8'hA5, 8'd2, 16'h0008, 4, 'h4000, 1);
        chk_counts("refill", 8, 4, 2, 256);
        drain();

        send_pkt(8'hA5, 8'd2, 16'h0009, 4, 'h5000, 1);
        chk("pending_level", 32'(fifo_level), 2);
        send_word(32'hA502_0020, 0);
        send_word(32'hEE00_6000, 0);
        s_axis_tdata  = 32'hEE00_6001;
        s_axis_tvalid = 1;
        #3 ARESET = 1;
        #1;
        chk("midrst_valid", {31'd0, m_frame_valid}, 0);
        chk("midrst_tready", {31'd0, s_axis_tready}, 0);
        chk("midrst_left", {8'd0, m_frame_left}, 0);
        chk("midrst_right", {8'd0, m_frame_right}, 0);
        chk_counts("midrst", 0, 0, 0, 0);
        expq.delete();
        s_axis_tvalid = 0;
        @(posedge ACLK);
        #1 ARESET = 0;
        @(posedge ACLK);
        #1;
        send_pkt(8'hA5, 8'd2, 16'h1234, 4, 'h7000, 1);
        chk_counts("after_rst", 1, 0, 0, 2);
        drain();
        send_pkt(8'hA5, 8'd1, 16'h2000, 2, 'h8000, 1);
        chk_counts("after_rst_gap", 2, 0, 1, 1);
        drain();
        chk("queue_empty", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
